// File: rtl/bfu_pkg.sv
// Shared constants and fixed-point helpers for the radix-2 butterfly datapath.
package bfu_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;

    typedef struct packed {
        logic                ovf;
        logic signed [63:0]  val;
    } sat_res_t;

    // Half-LSB of the product after the Q1.(TW-1) renormalising shift.
    function automatic logic signed [63:0] rnd_const(input int tw);
        return 64'sd1 <<< (tw - 2);
    endfunction

    function automatic sat_res_t sat(input logic signed [63:0] x, input int dw);
        sat_res_t           r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (dw - 1));
        r.ovf = 1'b1;
        if (x > hi) begin
            r.val = hi;
        end else if (x < lo) begin
            r.val = lo;
        end else begin
            r.val = x;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bfu_pipe_cmul_pipe.sv
// Two-stage complex multiplier W*B with optional twiddle conjugation and
// round-half-up back to DW+2 bits; advances only when the shared enable is high.
module cmul_pipe
    import bfu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_b_r,
    input  logic signed [DW-1:0] i_b_i,
    input  logic signed [TW-1:0] i_cos,
    input  logic signed [TW-1:0] i_sin,
    input  logic                 i_inverse,
    output logic signed [DW+1:0] o_wb_r,
    output logic signed [DW+1:0] o_wb_i
);

    localparam int PW = DW + TW + 1;
    localparam int SW = PW + 1;
    localparam int OW = DW + 2;

    logic signed [TW:0]   w_cos_x;
    logic signed [TW:0]   w_sin_x;
    logic signed [TW:0]   w_s;
    logic signed [PW-1:0] w_p_rc, w_p_is, w_p_rs, w_p_ic;
    logic signed [SW-1:0] w_sum_r, w_sum_i;

    logic signed [PW-1:0] r_p_rc, r_p_is, r_p_rs, r_p_ic;
    logic signed [OW-1:0] r_wb_r, r_wb_i;

    // One extra bit so that negating the most-negative sine stays exact.
    assign w_cos_x = {i_cos[TW-1], i_cos};
    assign w_sin_x = {i_sin[TW-1], i_sin};
    assign w_s     = i_inverse ? -w_sin_x : w_sin_x;

    assign w_p_rc = PW'(i_b_r) * PW'(w_cos_x);
    assign w_p_is = PW'(i_b_i) * PW'(w_s);
    assign w_p_rs = PW'(i_b_r) * PW'(w_s);
    assign w_p_ic = PW'(i_b_i) * PW'(w_cos_x);

    assign w_sum_r = SW'(r_p_rc) - SW'(r_p_is) + SW'(rnd_const(TW));
    assign w_sum_i = SW'(r_p_rs) + SW'(r_p_ic) + SW'(rnd_const(TW));

    // NOTE: state is updated only with non-blocking assignments so every
    // stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_rc <= '0;
            r_p_is <= '0;
            r_p_rs <= '0;
            r_p_ic <= '0;
            r_wb_r <= '0;
            r_wb_i <= '0;
        end else if (i_en) begin
            r_p_rc <= w_p_rc;
            r_p_is <= w_p_is;
            r_p_rs <= w_p_rs;
            r_p_ic <= w_p_ic;
            r_wb_r <= OW'(w_sum_r >>> (TW - 1));
            r_wb_i <= OW'(w_sum_i >>> (TW - 1));
        end
    end

    assign o_wb_r = r_wb_r;
    assign o_wb_i = r_wb_i;

endmodule

// File: rtl/bfu_pipe.sv
// Pipelined radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B, with
// valid/ready stalling, optional divide-by-2 and saturation with ovf flag.
module bfu_pipe
    import bfu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_r_in,
    input  logic signed [DW-1:0] a_i_in,
    input  logic signed [DW-1:0] b_r_in,
    input  logic signed [DW-1:0] b_i_in,
    input  logic signed [TW-1:0] cos_k,
    input  logic signed [TW-1:0] sin_k,
    input  logic                 inverse,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] a_r_out,
    output logic signed [DW-1:0] a_i_out,
    output logic signed [DW-1:0] b_r_out,
    output logic signed [DW-1:0] b_i_out,
    output logic                 ovf
);

    localparam int AW = DW + 3;

    logic                 w_en;
    logic signed [DW+1:0] w_wb_r, w_wb_i;
    logic signed [AW-1:0] w_sc_ar, w_sc_ai, w_sc_br, w_sc_bi;
    sat_res_t             w_sat_ar, w_sat_ai, w_sat_br, w_sat_bi;

    logic                 r_v1, r_v2, r_v3;
    logic                 r_scale1, r_scale2;
    logic signed [DW-1:0] r_a_r1, r_a_i1, r_a_r2, r_a_i2;
    logic signed [DW-1:0] r_a_r_out, r_a_i_out, r_b_r_out, r_b_i_out;
    logic                 r_ovf;

    // All stages move together; a result waiting at the output freezes the pipe.
    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;

    cmul_pipe #(.DW(DW), .TW(TW)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_en),
        .i_b_r     (b_r_in),
        .i_b_i     (b_i_in),
        .i_cos     (cos_k),
        .i_sin     (sin_k),
        .i_inverse (inverse),
        .o_wb_r    (w_wb_r),
        .o_wb_i    (w_wb_i)
    );

    function automatic logic signed [AW-1:0] half(input logic signed [AW-1:0] x,
                                                  input logic en);
        return en ? (x + AW'(1)) >>> 1 : x;
    endfunction

    assign w_sc_ar = half(AW'(r_a_r2) + AW'(w_wb_r), r_scale2);
    assign w_sc_ai = half(AW'(r_a_i2) + AW'(w_wb_i), r_scale2);
    assign w_sc_br = half(AW'(r_a_r2) - AW'(w_wb_r), r_scale2);
    assign w_sc_bi = half(AW'(r_a_i2) - AW'(w_wb_i), r_scale2);

    assign w_sat_ar = sat(64'(w_sc_ar), DW);
    assign w_sat_ai = sat(64'(w_sc_ai), DW);
    assign w_sat_br = sat(64'(w_sc_br), DW);
    assign w_sat_bi = sat(64'(w_sc_bi), DW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_scale1  <= 1'b0;
            r_scale2  <= 1'b0;
            r_a_r1    <= '0;
            r_a_i1    <= '0;
            r_a_r2    <= '0;
            r_a_i2    <= '0;
            r_a_r_out <= '0;
            r_a_i_out <= '0;
            r_b_r_out <= '0;
            r_b_i_out <= '0;
            r_ovf     <= 1'b0;
        end else if (w_en) begin
            r_v1      <= in_valid;
            r_scale1  <= scale;
            r_a_r1    <= a_r_in;
            r_a_i1    <= a_i_in;
            r_v2      <= r_v1;
            r_scale2  <= r_scale1;
            r_a_r2    <= r_a_r1;
            r_a_i2    <= r_a_i1;
            r_v3      <= r_v2;
            r_a_r_out <= DW'(w_sat_ar.val);
            r_a_i_out <= DW'(w_sat_ai.val);
            r_b_r_out <= DW'(w_sat_br.val);
            r_b_i_out <= DW'(w_sat_bi.val);
            r_ovf     <= w_sat_ar.ovf | w_sat_ai.ovf | w_sat_br.ovf | w_sat_bi.ovf;
        end
    end

    assign out_valid = r_v3;
    assign a_r_out   = r_a_r_out;
    assign a_i_out   = r_a_i_out;
    assign b_r_out   = r_b_r_out;
    assign b_i_out   = r_b_i_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bfu_pipe.sv
// Self-checking bench for bfu_pipe: vector table, scoreboard, stall, bubble and reset cases.
module tb_bfu_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    typedef struct packed {
        logic [15:0] ar, ai, br, bi, c, s;
        logic        inv, scl;
    } stim_t;

    typedef struct packed {
        logic [15:0] ar, ai, br, bi;
        logic        ovf;
    } res_t;

    typedef struct packed {
        stim_t st;
        res_t  ex;
    } vec_t;

    typedef struct {
        res_t ex;
        int   acc_cyc;
        bit   chk_lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, inverse, scale, out_valid, out_ready, ovf;
    logic [15:0] a_r_in, a_i_in, b_r_in, b_i_in, cos_k, sin_k;
    logic [15:0] a_r_out, a_i_out, b_r_out, b_i_out;

    sb_t  q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t tbl[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bfu_pipe #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_r_in    (a_r_in),
        .a_i_in    (a_i_in),
        .b_r_in    (b_r_in),
        .b_i_in    (b_i_in),
        .cos_k     (cos_k),
        .sin_k     (sin_k),
        .inverse   (inverse),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_r_out   (a_r_out),
        .a_i_out   (a_i_out),
        .b_r_out   (b_r_out),
        .b_i_out   (b_i_out),
        .ovf       (ovf)
    );

    task automatic check(input string name, input bit ok,
                         input logic [127:0] got, input logic [127:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] ar, ai, br, bi, c, s,
                                input logic inv, scl,
                                input logic [15:0] xar, xai, xbr, xbi,
                                input logic xo);
        vec_t v;
        v.st = '{ar, ai, br, bi, c, s, inv, scl};
        v.ex = '{xar, xai, xbr, xbi, xo};
        return v;
    endfunction

    // Reference: exact integer arithmetic, round half up, clamp to DW bits.
    function automatic res_t model(input stim_t st);
        longint ar, ai, br, bi, c, s, wr, wi;
        longint x[4];
        bit     o;
        res_t   r;
        o  = 1'b0;
        ar = longint'($signed(st.ar));
        ai = longint'($signed(st.ai));
        br = longint'($signed(st.br));
        bi = longint'($signed(st.bi));
        c  = longint'($signed(st.c));
        s  = st.inv ? -longint'($signed(st.s)) : longint'($signed(st.s));
        wr = (br * c - bi * s + 64'sd16384) >>> 15;
        wi = (br * s + bi * c + 64'sd16384) >>> 15;
        x[0] = ar + wr;
        x[1] = ai + wi;
        x[2] = ar - wr;
        x[3] = ai - wi;
        for (int i = 0; i < 4; i++) begin
            if (st.scl) x[i] = (x[i] + 64'sd1) >>> 1;
            if (x[i] > 64'sd32767) begin
                x[i] = 64'sd32767;
                o = 1'b1;
            end else if (x[i] < -64'sd32768) begin
                x[i] = -64'sd32768;
                o = 1'b1;
            end
        end
        r = '{16'(x[0]), 16'(x[1]), 16'(x[2]), 16'(x[3]), o};
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r = '{a_r_out, a_i_out, b_r_out, b_i_out, ovf};
        return r;
    endfunction

    // Output monitor: scoreboard pop, latency, and hold-while-stalled checks.
    res_t held_val;
    bit   held = 1'b0;
    always @(negedge clk) begin
        sb_t  e;
        res_t c;
        c = cur_out();
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                check("hold", out_valid && (c == held_val), 128'({out_valid, c}),
                      128'({1'b1, held_val}));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1'b0, 128'(c), 128'(0));
                end else begin
                    e = q.pop_front();
                    check("result", c == e.ex, 128'(c), 128'(e.ex));
                    if (e.chk_lat)
                        check("latency", (cyc - e.acc_cyc) == 3, 128'(cyc - e.acc_cyc), 128'(3));
                end
            end
            held     = out_valid && !out_ready;
            held_val = c;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input stim_t st);
        a_r_in  = st.ar;
        a_i_in  = st.ai;
        b_r_in  = st.br;
        b_i_in  = st.bi;
        cos_k   = st.c;
        sin_k   = st.s;
        inverse = st.inv;
        scale   = st.scl;
    endtask

    task automatic send(input stim_t st, input res_t ex, input bit lat);
        sb_t e;
        drive(st);
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (in_ready) begin
                e.ex      = ex;
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                q.push_back(e);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("accept_timeout", 1'b0, 128'(0), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && q.size() > 0; k++) tick();
        check("drain", q.size() == 0, 128'(q.size()), 128'(0));
        repeat (4) tick();
    endtask

    initial begin
        stim_t rs[6];
        res_t  rx[6];
        int    idx;

        tbl[0] = mk(16'd1000, 16'd0, 16'd200, 16'd0, 16'h8000, 16'h0000, 1'b0, 1'b0,
                    16'd800, 16'd0, 16'd1200, 16'd0, 1'b0);
        tbl[1] = mk(16'd0, 16'd0, 16'd1000, 16'd0, 16'h0000, 16'h7FFF, 1'b0, 1'b0,
                    16'd0, 16'd1000, 16'd0, 16'hFC18, 1'b0);
        tbl[2] = mk(16'd0, 16'd0, 16'd1000, 16'd0, 16'h0000, 16'h7FFF, 1'b1, 1'b0,
                    16'd0, 16'hFC18, 16'd0, 16'd1000, 1'b0);
        tbl[3] = mk(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h8000, 16'h0000, 1'b0, 1'b0,
                    16'd0, 16'd0, 16'h7FFF, 16'd0, 1'b1);
        tbl[4] = mk(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h8000, 16'h0000, 1'b0, 1'b1,
                    16'd0, 16'd0, 16'h7FFF, 16'd0, 1'b0);
        tbl[5] = mk(16'd100, 16'hFFCE, 16'd300, 16'd400, 16'h7FFF, 16'h0000, 1'b0, 1'b0,
                    16'd400, 16'd350, 16'hFF38, 16'hFE3E, 1'b0);
        tbl[6] = mk(16'hFFFD, 16'd5, 16'd0, 16'd0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                    16'hFFFF, 16'd3, 16'hFFFF, 16'd3, 1'b0);
        tbl[7] = mk(16'd0, 16'd0, 16'd0, 16'd100, 16'h0000, 16'h8000, 1'b1, 1'b0,
                    16'hFF9C, 16'd0, 16'd100, 16'd0, 1'b0);
        tbl[8] = mk(16'h8000, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'h0000, 1'b0, 1'b0,
                    16'hFFFE, 16'd0, 16'h8000, 16'd0, 1'b1);
        tbl[9] = mk(16'd0, 16'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0,
                    16'd0, 16'h7FFF, 16'd0, 16'h8000, 1'b1);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(tbl[0].st);

        #1;
        check("reset_state", {out_valid, ovf, a_r_out, a_i_out, b_r_out, b_i_out} == '0,
              128'({out_valid, ovf, a_r_out, a_i_out, b_r_out, b_i_out}), 128'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Directed vectors, back to back at full rate.
        for (int i = 0; i < 10; i++) send(tbl[i].st, tbl[i].ex, 1'b1);
        drain();

        // Bubble: valid pattern 1,0,1 must reappear three cycles later.
        send(tbl[0].st, tbl[0].ex, 1'b1);
        tick();
        send(tbl[5].st, tbl[5].ex, 1'b1);
        @(negedge clk);
        check("bubble_0", out_valid == 1'b1, 128'(out_valid), 128'(1));
        @(negedge clk);
        check("bubble_1", out_valid == 1'b0, 128'(out_valid), 128'(0));
        @(negedge clk);
        check("bubble_2", out_valid == 1'b1, 128'(out_valid), 128'(1));
        tick();
        drain();

        // Back-pressure: six random bundles, out_ready low in cycles 4..7.
        for (int i = 0; i < 6; i++) begin
            rs[i] = '{16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
                      16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom())};
            rx[i] = model(rs[i]);
        end
        idx = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            sb_t e;
            out_ready = !(k >= 4 && k <= 7);
            drive(rs[idx]);
            in_valid = 1'b1;
            #1;
            if (k >= 4 && k <= 7)
                check("stall_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
            if (in_ready) begin
                e.ex      = rx[idx];
                e.acc_cyc = cyc;
                e.chk_lat = 1'b0;
                q.push_back(e);
                idx++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_accepted", idx == 6, 128'(idx), 128'(6));
        drain();

        // Reset with bundles in flight: everything is discarded at once.
        send(tbl[3].st, tbl[3].ex, 1'b1);
        send(tbl[0].st, tbl[0].ex, 1'b1);
        send(tbl[1].st, tbl[1].ex, 1'b1);
        #1;
        check("pre_reset_out", {out_valid, ovf} == 2'b11, 128'({out_valid, ovf}), 128'(3));
        #1 rst = 1'b1;
        #1;
        check("async_reset", {out_valid, ovf, a_r_out, a_i_out, b_r_out, b_i_out} == '0,
              128'({out_valid, ovf, a_r_out, a_i_out, b_r_out, b_i_out}), 128'(0));
        q.delete();
        @(posedge clk);
        #4 rst = 1'b0;
        send(tbl[5].st, tbl[5].ex, 1'b1);
        drain();
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
